// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: controller-side sequencer for mac_array_8x.
// Packs LANES (data, weight) byte pairs into one vector and hands it to the
// array. Each vector gets a clear pulse and then an enable pulse. The
// returned partial sums are accumulated over len vectors, and one signed dot
// product is presented on a valid/ready result port.
module mac_dot_sequencer #(
    parameter int LANES   = 8,
    parameter int LEN_W   = 8,
    parameter int ACC_W   = 24,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    input  logic [7:0]           s_weight,
    output logic                 mac_clear,
    output logic                 mac_enable,
    output logic [8*LANES-1:0]   mac_data,
    output logic [8*LANES-1:0]   mac_weight,
    input  logic [15:0]          mac_partial_sum,
    input  logic                 mac_valid,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_W-1:0]     res_data,
    output logic                 res_overflow,
    output logic                 res_error
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CLEAR = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [LEN_W-1:0]     remain_r;
    logic [IDX_W-1:0]     idx_r;
    logic [8*LANES-1:0]   data_lanes_r;
    logic [8*LANES-1:0]   weight_lanes_r;
    logic [ACC_W-1:0]     acc_r;
    logic                 ovf_r;
    logic                 err_r;
    logic [TO_W-1:0]      tout_r;

    logic                 busy_r;
    logic                 s_ready_r;
    logic                 mac_clear_r;
    logic                 mac_enable_r;
    logic                 res_valid_r;

    logic                 beat_s;
    logic                 last_beat_s;
    logic                 timeout_s;
    logic [ACC_W-1:0]     sum_ext_s;
    logic [ACC_W-1:0]     acc_sum_s;
    logic                 add_ovf_s;

    // Signed add overflow: operands agree in sign, result disagrees.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                          input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Beat acceptance, timeout detection and accumulator arithmetic.
    always_comb begin
        beat_s      = s_valid && s_ready_r;
        last_beat_s = beat_s && (idx_r == IDX_W'(LANES - 1));
        // The enable cycle counts as the first elapsed cycle, so the
        // error result appears exactly TIMEOUT cycles after mac_enable.
        timeout_s   = (tout_r == TO_W'(TIMEOUT - 2));
        sum_ext_s   = {{(ACC_W-16){mac_partial_sum[15]}}, mac_partial_sum};
        acc_sum_s   = acc_r + sum_ext_s;
        add_ovf_s   = add_overflow(acc_r[ACC_W-1], sum_ext_s[ACC_W-1],
                                   acc_sum_s[ACC_W-1]);
    end

    // Next-state decode of the job sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len == LEN_W'(0)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (last_beat_s) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_CLEAR: state_nxt_s = ST_ISSUE;
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (mac_valid) begin
                    if (remain_r == LEN_W'(1)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here
                if (res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus registered control outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            s_ready_r    <= 1'b0;
            mac_clear_r  <= 1'b0;
            mac_enable_r <= 1'b0;
            res_valid_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            s_ready_r    <= (state_nxt_s == ST_LOAD);
            mac_clear_r  <= (state_nxt_s == ST_CLEAR);
            mac_enable_r <= (state_nxt_s == ST_ISSUE);
            res_valid_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Lane packing, vector counting and the timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remain_r       <= {LEN_W{1'b0}};
            idx_r          <= {IDX_W{1'b0}};
            data_lanes_r   <= {(8*LANES){1'b0}};
            weight_lanes_r <= {(8*LANES){1'b0}};
            tout_r         <= {TO_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        remain_r <= len;
                        idx_r    <= {IDX_W{1'b0}};
                    end
                end
                ST_LOAD: begin
                    if (beat_s) begin
                        data_lanes_r[{idx_r, 3'b000} +: 8]   <= s_data;
                        weight_lanes_r[{idx_r, 3'b000} +: 8] <= s_weight;
                        if (last_beat_s) begin
                            idx_r <= {IDX_W{1'b0}};
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_ISSUE: tout_r <= {TO_W{1'b0}};
                ST_WAIT: begin
                    tout_r <= tout_r + TO_W'(1);
                    if (mac_valid) begin
                        remain_r <= remain_r - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulator and the sticky overflow / error flags of the current job.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end else if (state_r == ST_WAIT) begin
            if (mac_valid) begin
                acc_r <= acc_sum_s;
                ovf_r <= ovf_r | add_ovf_s;
            end else if (timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign busy         = busy_r;
    assign s_ready      = s_ready_r;
    assign mac_clear    = mac_clear_r;
    assign mac_enable   = mac_enable_r;
    assign mac_data     = data_lanes_r;
    assign mac_weight   = weight_lanes_r;
    assign res_valid    = res_valid_r;
    assign res_data     = acc_r;
    assign res_overflow = ovf_r;
    assign res_error    = err_r;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer. A behavioural mac_array_8x answers each
// enable. Expected job results are queued when a job is started and are
// compared when the result handshake appears.
module tb_mac_dot_sequencer;

    localparam int LANES   = 8;
    localparam int LEN_W   = 8;
    localparam int ACC_W   = 20;
    localparam int TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [LEN_W-1:0]     len = '0;
    logic                 busy;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [7:0]           s_data = 8'd0;
    logic [7:0]           s_weight = 8'd0;
    logic                 mac_clear;
    logic                 mac_enable;
    logic [8*LANES-1:0]   mac_data;
    logic [8*LANES-1:0]   mac_weight;
    logic [15:0]          mac_partial_sum = 16'd0;
    logic                 mac_valid = 1'b0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [ACC_W-1:0]     res_data;
    logic                 res_overflow;
    logic                 res_error;

    mac_dot_sequencer #(
        .LANES(LANES), .LEN_W(LEN_W), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_weight(s_weight),
        .mac_clear(mac_clear), .mac_enable(mac_enable), .mac_data(mac_data),
        .mac_weight(mac_weight), .mac_partial_sum(mac_partial_sum),
        .mac_valid(mac_valid), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_overflow(res_overflow), .res_error(res_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit ovf;
        bit err;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           en_cnt = 0;
    int           en_cyc = 0;
    logic         prev_en = 1'b0;
    logic         prev_clr = 1'b0;
    int           mac_mode = 0;      // 0: true products, 1: fixed sum, 2: silent
    int           mac_delay = 1;
    logic [15:0]  mac_fixed = 16'd0;
    logic [63:0]  cap_data = 64'd0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Protocol monitor: pulse widths, clear->enable order, s_ready only in LOAD.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("clear_width", {31'd0, prev_clr && mac_clear}, 0);
                chk("enable_width", {31'd0, prev_en && mac_enable}, 0);
                if (prev_clr) chk("enable_after_clear", {31'd0, mac_enable}, 1);
                chk("s_ready_state",
                    {31'd0, s_ready && (mac_clear || mac_enable || res_valid || !busy)}, 0);
                if (mac_enable) begin
                    en_cnt++;
                    en_cyc = cyc;
                end
                prev_clr = mac_clear;
                prev_en  = mac_enable;
            end else begin
                prev_clr = 1'b0;
                prev_en  = 1'b0;
            end
        end
    end

    // Behavioural MAC array: answers an enable pulse after mac_delay edges.
    initial begin
        int s;
        int a;
        int b;
        forever begin
            @(negedge clk);
            if (mac_enable && rst_n) begin
                cap_data = mac_data;
                s = 0;
                for (int i = 0; i < LANES; i++) begin
                    a = $signed(mac_data[8*i +: 8]);
                    b = $signed(mac_weight[8*i +: 8]);
                    s += a * b;
                end
                if (mac_mode != 2) begin
                    repeat (mac_delay) @(posedge clk);
                    #1;
                    mac_valid = 1'b1;
                    mac_partial_sum = (mac_mode == 1) ? mac_fixed : s[15:0];
                    @(posedge clk);
                    #1;
                    mac_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [7:0] d, input logic [7:0] w);
        int n = 0;
        s_valid  = 1'b1;
        s_data   = d;
        s_weight = w;
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("beat_timeout", n, 0);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [63:0] dv, input logic [63:0] wv, input bit gap);
        for (int i = 0; i < LANES; i++) begin
            send_beat(dv[8*i +: 8], wv[8*i +: 8]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic start_job(input int l, input int e_data, input bit e_ovf, input bit e_err);
        exp_t e;
        e.data = e_data;
        e.ovf  = e_ovf;
        e.err  = e_err;
        exp_q.push_back(e);
        start = 1'b1;
        len   = LEN_W'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!res_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk({tag, "_res_timeout"}, n, 0);
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        wait_valid(tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, $signed(res_data), e.data);
            chk({tag, "_ovf"}, {31'd0, res_overflow}, {31'd0, e.ovf});
            chk({tag, "_err"}, {31'd0, res_error}, {31'd0, e.err});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, res_valid}, 0);
        chk({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    initial begin
        int en0;
        logic [7:0] lane;
        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_s_ready", {31'd0, s_ready}, 0);
        chk("rst_ctrl", {29'd0, mac_clear, mac_enable, res_valid}, 0);
        chk("rst_res_data", $signed(res_data), 0);
        chk("rst_mac_data", {31'd0, mac_data != 64'd0}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // one vector of (1,1)
        en0 = en_cnt;
        mac_mode = 0; mac_delay = 1;
        start_job(1, 8, 1'b0, 1'b0);
        send_vec(64'h0101010101010101, 64'h0101010101010101, 1'b0);
        wait_result("ones");
        chk("ones_enables", en_cnt - en0, 1);

        // two vectors of (2,3) with gaps on s_valid, slower array
        en0 = en_cnt;
        mac_delay = 3;
        start_job(2, 96, 1'b0, 1'b0);
        send_vec(64'h0202020202020202, 64'h0303030303030303, 1'b1);
        send_vec(64'h0202020202020202, 64'h0303030303030303, 1'b1);
        wait_result("gaps");
        chk("gaps_enables", en_cnt - en0, 2);

        // mixed signs cancel; check lane placement
        mac_delay = 1;
        start_job(1, 0, 1'b0, 1'b0);
        send_vec(64'hFC04FF01FD03FE02, 64'h0202020202020202, 1'b0);
        wait_result("signs");
        lane = cap_data[7:0];
        chk("lane0", {24'd0, lane}, 32'h02);
        lane = cap_data[63:56];
        chk("lane7", {24'd0, lane}, 32'hFC);

        // len=0: straight to DONE, held while res_ready low, start ignored
        en0 = en_cnt;
        start_job(0, 0, 1'b0, 1'b0);
        begin
            int n = 0;
            while (!res_valid && n < 2) begin
                @(negedge clk);
                n++;
            end
        end
        chk("zero_valid", {31'd0, res_valid}, 1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            len   = 8'd3;
            @(negedge clk);
            chk("zero_hold_valid", {31'd0, res_valid}, 1);
            chk("zero_hold_data", $signed(res_data), 0);
            chk("zero_hold_flags", {30'd0, res_overflow, res_error}, 0);
        end
        start = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        res_ready = 1'b0;
        chk("zero_valid_drop", {31'd0, res_valid}, 0);
        @(negedge clk);
        chk("zero_start_ignored", {31'd0, busy}, 0);
        chk("zero_no_enable", en_cnt - en0, 0);

        // accumulator wrap over 17 vectors of 0x7FFF
        mac_mode = 1; mac_fixed = 16'h7FFF;
        start_job(17, -491537, 1'b1, 1'b0);
        for (int v = 0; v < 17; v++) send_vec(64'd0, 64'd0, 1'b0);
        wait_result("wrap");
        mac_fixed = 16'd16;
        start_job(1, 16, 1'b0, 1'b0);
        send_vec(64'd0, 64'd0, 1'b0);
        wait_result("after_wrap");

        // array never answers
        mac_mode = 2;
        start_job(1, 0, 1'b0, 1'b1);
        send_vec(64'h0101010101010101, 64'h0101010101010101, 1'b0);
        wait_valid("tmo");
        chk("tmo_latency", cyc - en_cyc, TIMEOUT);
        wait_result("tmo");

        // reset mid-LOAD, then a clean job
        mac_mode = 0;
        start = 1'b1; len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(8'd5, 8'd7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_s_ready", {31'd0, s_ready}, 0);
        start_job(1, 8, 1'b0, 1'b0);
        send_vec(64'h0101010101010101, 64'h0101010101010101, 1'b0);
        wait_result("midrst");
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
